// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared definitions for the game-progress controller and the
//                HUD/text renderer: game state / game_status codes and the
//                player_status codes reported by the player/physics logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // State register value doubles as the game_status code seen by the HUD.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_LEVEL_UP  = 3'd2,
        ST_WORLD_UP  = 3'd3,
        ST_LIFE_LOST = 3'd4,
        ST_LOSE      = 3'd5,
        ST_WIN       = 3'd6
    } game_state_e;

    // player_status codes; PS_RESERVED is treated exactly like PS_PLAYING.
    localparam logic [1:0] PS_PLAYING  = 2'd0;
    localparam logic [1:0] PS_PASS     = 2'd1;
    localparam logic [1:0] PS_DIED     = 2'd2;
    localparam logic [1:0] PS_RESERVED = 2'd3;

    // True for the three timed banner screens.
    function automatic logic is_banner(input game_state_e s);
        return (s == ST_LEVEL_UP) || (s == ST_WORLD_UP) || (s == ST_LIFE_LOST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/banner_timer.sv
`default_nettype none
// ============================================================================
//  Module      : banner_timer
//  Description : Banner hold counter. Counts up while 'run' is high and parks
//                at BANNER_CYCLES-1, where 'done' is asserted. 'clear' returns
//                the count to zero and has priority over 'run'.
//  Ports       : clk, reset (sync, active-high), clear, run -> done
//  Revision    : 1.0 - initial release
// ============================================================================
module banner_timer #(
    parameter  int BANNER_CYCLES = 100_000_000,
    localparam int TW            = $clog2(BANNER_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic done
);

    localparam logic [TW-1:0] c_last_count = TW'(BANNER_CYCLES - 1);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (run && (r_count != c_last_count)) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign done = (r_count == c_last_count);

endmodule
`default_nettype wire

// File: rtl/game_progress_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_progress_ctrl
//  Description : Game-progress controller. Tracks world, level and lives and
//                sequences IDLE -> PLAY -> banner screens -> LOSE / WIN.
//  Ports       : clk, reset        clock, synchronous active-high reset
//                start_button      level input, rising edge acts
//                player_status     0 playing, 1 pass, 2 died, 3 = 0
//                extra_life        one-cycle pickup pulse
//                pause             freezes play and banner timing
//                game_status       state code (registered)
//                world/level/lives progress counters (registered)
//                banner_active     high on LEVEL_UP/WORLD_UP/LIFE_LOST
//  Revision    : 1.0 - initial release
// ============================================================================
module game_progress_ctrl
    import game_pkg::*;
#(
    parameter  int NUM_WORLDS       = 3,
    parameter  int LEVELS_PER_WORLD = 7,
    parameter  int START_LIVES      = 3,
    parameter  int MAX_LIVES        = 9,
    parameter  int BANNER_CYCLES    = 100_000_000,
    localparam int WW = (NUM_WORLDS > 1)       ? $clog2(NUM_WORLDS)       : 1,
    localparam int LW = (LEVELS_PER_WORLD > 1) ? $clog2(LEVELS_PER_WORLD) : 1,
    localparam int HW = $clog2(MAX_LIVES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_button,
    input  logic [1:0]    player_status,
    input  logic          extra_life,
    input  logic          pause,
    output logic [2:0]    game_status,
    output logic [WW-1:0] world,
    output logic [LW-1:0] level,
    output logic [HW-1:0] lives,
    output logic          banner_active
);

    localparam logic [WW-1:0] c_last_world  = WW'(NUM_WORLDS - 1);
    localparam logic [LW-1:0] c_last_level  = LW'(LEVELS_PER_WORLD - 1);
    localparam logic [HW-1:0] c_max_lives   = HW'(MAX_LIVES);
    localparam logic [HW-1:0] c_start_lives = HW'(START_LIVES);
    localparam logic [HW-1:0] c_one_life    = HW'(1);

    game_state_e   r_state;
    game_state_e   w_next_state;
    logic [WW-1:0] r_world;
    logic [WW-1:0] w_world_nxt;
    logic [LW-1:0] r_level;
    logic [LW-1:0] w_level_nxt;
    logic [HW-1:0] r_lives;
    logic [HW-1:0] w_lives_nxt;
    logic [HW-1:0] w_lives_up;
    logic          r_banner_active;
    logic          w_banner_nxt;

    logic          r_btn_prev;
    logic          r_start_edge;

    logic          w_pass;
    logic          w_died;
    logic          w_in_banner;
    logic          w_timer_done;
    logic          w_timer_run;
    logic          w_timer_clear;
    logic          w_expire;

    // ------------------------------------------------------------------------
    // Start-button edge detect. The previous-sample flop comes out of reset
    // as "high" so a button held through reset must be released and pressed
    // again. The detected edge is registered, so control reacts on the second
    // clock edge after the rise.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_prev   <= 1'b1;
            r_start_edge <= 1'b0;
        end else begin
            r_btn_prev   <= start_button;
            r_start_edge <= start_button & ~r_btn_prev;
        end
    end

    // ------------------------------------------------------------------------
    // Status decode and banner timing
    // ------------------------------------------------------------------------
    assign w_pass      = (player_status == PS_PASS);
    assign w_died      = (player_status == PS_DIED);
    assign w_in_banner = is_banner(r_state);

    // Leaving a banner also needs status released, otherwise a pass/died
    // that is still being reported would be counted a second time.
    assign w_expire      = w_in_banner & ~pause & w_timer_done & ~(w_pass | w_died);
    assign w_timer_run   = w_in_banner & ~pause & ~w_timer_done;
    // Held at zero outside banners, so every banner starts from zero.
    assign w_timer_clear = ~w_in_banner | w_expire;

    banner_timer #(
        .BANNER_CYCLES (BANNER_CYCLES)
    ) u_banner_timer (
        .clk   (clk),
        .reset (reset),
        .clear (w_timer_clear),
        .run   (w_timer_run),
        .done  (w_timer_done)
    );

    assign w_lives_up = (r_lives == c_max_lives) ? r_lives : (r_lives + c_one_life);

    // ------------------------------------------------------------------------
    // FSM: state register (with counters and registered outputs)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_world         <= '0;
            r_level         <= '0;
            r_lives         <= c_start_lives;
            r_banner_active <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_world         <= w_world_nxt;
            r_level         <= w_level_nxt;
            r_lives         <= w_lives_nxt;
            r_banner_active <= w_banner_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state and counter update
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_world_nxt  = r_world;
        w_level_nxt  = r_level;
        w_lives_nxt  = r_lives;

        case (r_state)
            ST_IDLE: begin
                if (r_start_edge) begin
                    w_next_state = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (extra_life) begin
                    w_lives_nxt = w_lives_up;
                end
                if (!pause) begin
                    if (w_pass) begin
                        if (r_level < c_last_level) begin
                            w_level_nxt  = r_level + LW'(1);
                            w_next_state = ST_LEVEL_UP;
                        end else if (r_world < c_last_world) begin
                            w_level_nxt  = '0;
                            w_world_nxt  = r_world + WW'(1);
                            w_next_state = ST_WORLD_UP;
                        end else begin
                            w_next_state = ST_WIN;
                        end
                    end else if (w_died) begin
                        if (extra_life) begin
                            // Pickup and death cancel; cannot be the last life.
                            w_lives_nxt  = r_lives;
                            w_next_state = ST_LIFE_LOST;
                        end else begin
                            // PLAY always holds at least one life.
                            w_lives_nxt  = r_lives - c_one_life;
                            w_next_state = (r_lives == c_one_life) ? ST_LOSE : ST_LIFE_LOST;
                        end
                    end
                end
            end

            ST_LEVEL_UP, ST_WORLD_UP, ST_LIFE_LOST: begin
                if (extra_life) begin
                    w_lives_nxt = w_lives_up;
                end
                if (w_expire) begin
                    w_next_state = ST_PLAY;
                end
            end

            ST_LOSE, ST_WIN: begin
                if (r_start_edge) begin
                    w_next_state = ST_IDLE;
                    w_world_nxt  = '0;
                    w_level_nxt  = '0;
                    w_lives_nxt  = c_start_lives;
                end
            end

            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode (registered in the state process)
    // ------------------------------------------------------------------------
    always_comb begin
        w_banner_nxt = is_banner(w_next_state);
    end

    assign game_status   = r_state;
    assign world         = r_world;
    assign level         = r_level;
    assign lives         = r_lives;
    assign banner_active = r_banner_active;

endmodule
`default_nettype wire

// File: tb/tb_game_progress_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_progress_ctrl
//  Description : Self-checking bench for game_progress_ctrl. A behavioural
//                game model is compared against the DUT every cycle; directed
//                scenarios add literal expectations, followed by random play.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_game_progress_ctrl;

    localparam int NW = 2;
    localparam int LPW = 3;
    localparam int SL = 2;
    localparam int ML = 3;
    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_button = 1'b0;
    logic [1:0] player_status = 2'd0;
    logic       extra_life = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] game_status;
    logic [0:0] world;
    logic [1:0] level;
    logic [1:0] lives;
    logic       banner_active;

    int n_checks = 0;
    int n_fail = 0;

    game_progress_ctrl #(
        .NUM_WORLDS       (NW),
        .LEVELS_PER_WORLD (LPW),
        .START_LIVES      (SL),
        .MAX_LIVES        (ML),
        .BANNER_CYCLES    (BC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start_button  (start_button),
        .player_status (player_status),
        .extra_life    (extra_life),
        .pause         (pause),
        .game_status   (game_status),
        .world         (world),
        .level         (level),
        .lives         (lives),
        .banner_active (banner_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model (game rules, integer state codes 0..6)
    // ------------------------------------------------------------------------
    int m_state = 0;
    int m_world = 0;
    int m_level = 0;
    int m_lives = SL;
    int m_elapsed = 0;   // unpaused banner clocks already spent
    bit m_btn1 = 1'b1;   // button sample one edge ago
    bit m_btn2 = 1'b1;   // button sample two edges ago
    bit m_valid = 1'b0;

    task automatic model_step();
        int  cur;
        bit  go;
        bit  pass_i;
        bit  died_i;
        if (reset) begin
            m_state = 0; m_world = 0; m_level = 0; m_lives = SL; m_elapsed = 0;
            m_btn1 = 1'b1; m_btn2 = 1'b1; m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        go = m_btn1 && !m_btn2;
        m_btn2 = m_btn1;
        m_btn1 = start_button;
        pass_i = (player_status == 2'd1);
        died_i = (player_status == 2'd2);
        cur = m_state;
        if (cur == 0) begin
            if (go) m_state = 1;
        end else if (cur == 1) begin
            if (!pause && died_i) begin
                if (!extra_life) m_lives = m_lives - 1;
                m_state = (m_lives == 0) ? 5 : 4;
                m_elapsed = 0;
            end else begin
                if (extra_life && m_lives < ML) m_lives = m_lives + 1;
                if (!pause && pass_i) begin
                    m_elapsed = 0;
                    if (m_level < LPW - 1) begin
                        m_level = m_level + 1; m_state = 2;
                    end else if (m_world < NW - 1) begin
                        m_level = 0; m_world = m_world + 1; m_state = 3;
                    end else begin
                        m_state = 6;
                    end
                end
            end
        end else if (cur >= 2 && cur <= 4) begin
            if (extra_life && m_lives < ML) m_lives = m_lives + 1;
            if (!pause) begin
                if (m_elapsed == BC - 1) begin
                    if (!pass_i && !died_i) begin
                        m_state = 1; m_elapsed = 0;
                    end
                end else begin
                    m_elapsed = m_elapsed + 1;
                end
            end
        end else begin
            if (go) begin
                m_state = 0; m_world = 0; m_level = 0; m_lives = SL;
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_status", game_status, m_state);
            check("model_world", world, m_world);
            check("model_level", level, m_level);
            check("model_lives", lives, m_lives);
            check("model_banner", banner_active, (m_state >= 2 && m_state <= 4));
        end
    end

    // ------------------------------------------------------------------------
    // Directed helpers (all drive on the falling edge)
    // ------------------------------------------------------------------------
    task automatic press_start(input string name, input int exp_state);
        @(negedge clk) start_button = 1'b1;
        @(negedge clk);
        @(negedge clk) start_button = 1'b0;
        check(name, game_status, exp_state);
    endtask

    task automatic pulse_status(input logic [1:0] s, input bit with_life,
                                input string name, input int exp_state);
        @(negedge clk) begin player_status = s; extra_life = with_life; end
        @(negedge clk) begin player_status = 2'd0; extra_life = 1'b0; end
        check(name, game_status, exp_state);
    endtask

    // Called at the first falling edge inside a banner; returns at the first
    // falling edge after it, with the measured length checked.
    task automatic measure_banner(input string name, input int exp_len,
                                  input int pause_from, input int pause_len);
        int  cnt;
        bit  ended;
        cnt = 0;
        ended = 1'b0;
        for (int i = 0; i < 60 && !ended; i++) begin
            if (banner_active) begin
                cnt++;
                if (pause_len > 0 && cnt == pause_from) pause = 1'b1;
                if (pause_len > 0 && cnt == pause_from + pause_len) pause = 1'b0;
                @(negedge clk);
            end else begin
                ended = 1'b1;
            end
        end
        pause = 1'b0;
        if (!ended) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: banner still active after 60 cycles", name);
        end
        check(name, cnt, exp_len);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Button held high across reset.
        start_button = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_status", game_status, 0);
        check("rst_world", world, 0);
        check("rst_level", level, 0);
        check("rst_lives", lives, SL);
        check("rst_banner", banner_active, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("held_btn_idle", game_status, 0);
        start_button = 1'b0;
        @(negedge clk);
        press_start("start_play", 1);

        // Full win.
        pulse_status(2'd1, 1'b0, "win_p1", 2); measure_banner("win_b1", BC, 0, 0);
        pulse_status(2'd1, 1'b0, "win_p2", 2); measure_banner("win_b2", BC, 0, 0);
        pulse_status(2'd1, 1'b0, "win_p3", 3); measure_banner("win_b3", BC, 0, 0);
        pulse_status(2'd1, 1'b0, "win_p4", 2); measure_banner("win_b4", BC, 0, 0);
        pulse_status(2'd1, 1'b0, "win_p5", 2); measure_banner("win_b5", BC, 0, 0);
        pulse_status(2'd1, 1'b0, "win_p6", 6);
        check("win_world", world, 1);
        check("win_level", level, 2);
        press_start("win_to_idle", 0);
        check("win_reload_world", world, 0);
        press_start("restart1", 1);

        // Lose.
        pulse_status(2'd2, 1'b0, "die1", 4);
        check("die1_lives", lives, 1);
        measure_banner("die1_banner", BC, 0, 0);
        pulse_status(2'd2, 1'b0, "die2", 5);
        check("die2_lives", lives, 0);
        press_start("lose_to_idle", 0);
        check("lose_reload_lives", lives, SL);
        press_start("restart2", 1);

        // Extra lives with saturation, then died together with a pickup.
        repeat (3) begin
            @(negedge clk) extra_life = 1'b1;
            @(negedge clk) extra_life = 1'b0;
        end
        check("extra_sat", lives, 3);
        pulse_status(2'd2, 1'b1, "die_plus_life", 4);
        check("die_plus_life_lives", lives, 3);
        measure_banner("die_plus_life_banner", BC, 0, 0);

        // Release handshake: pass held for 10 cycles.
        @(negedge clk) player_status = 2'd1;
        repeat (10) @(negedge clk);
        check("hold_in_banner", game_status, 2);
        player_status = 2'd0;
        @(negedge clk);
        check("release_to_play", game_status, 1);

        // Pause for 3 cycles mid-banner.
        pulse_status(2'd1, 1'b0, "pause_pass", 2);
        measure_banner("pause_banner", BC + 3, 2, 3);

        // Reset in WORLD_UP while paused.
        pulse_status(2'd1, 1'b0, "to_world_up", 3);
        @(negedge clk) begin reset = 1'b1; pause = 1'b1; end
        @(negedge clk);
        check("rst_mid_status", game_status, 0);
        check("rst_mid_world", world, 0);
        check("rst_mid_level", level, 0);
        check("rst_mid_lives", lives, SL);
        check("rst_mid_banner", banner_active, 0);
        reset = 1'b0;
        pause = 1'b0;

        // Random play, checked by the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 99) < 85) player_status = 2'd0;
            else player_status = 2'($urandom_range(1, 3));
            extra_life = ($urandom_range(0, 9) == 0);
            pause = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) start_button = ~start_button;
        end
        @(negedge clk) begin
            reset = 1'b0; player_status = 2'd0; extra_life = 1'b0; pause = 1'b0;
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
